// File: rtl/ser_pkg.sv
// Shared types and framing constants for the serial word capture stage.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/d_en_ff.sv
// Enabled D flop with asynchronous active-low clear; one bit of a register bank.
module d_en_ff (
  input  logic clk,
  input  logic CLRN,
  input  logic EN,
  input  logic D,
  output logic q
);

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN)   q <= 1'b0;
    else if (EN) q <= D;
  end

endmodule

// File: rtl/ser_word_capture.sv
// Serial-to-parallel capture: start bit, WIDTH data bits LSB first, stop bit.
// Presents the word with a rdy/ack handshake and sticky framing/overrun flags.
module ser_word_capture
  import ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             sdata,
  input  logic             sen,
  input  logic             ack,
  input  logic             clr_err,
  output logic [WIDTH-1:0] word,
  output logic             rdy,
  output logic             ferr,
  output logic             ovr,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             load, ovr_ev, ferr_ev;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    load     = 1'b0;
    ovr_ev   = 1'b0;
    ferr_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sen && sdata == START_BIT) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (sen) begin
          shreg_d[bitcnt_q] = sdata;
          // Hold the counter on the last bit so it never wraps inside a frame.
          if (bitcnt_q == CW'(WIDTH - 1)) state_d = STOP;
          else                            bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      STOP: begin
        if (sen) begin
          state_d = IDLE;
          if (sdata == STOP_BIT) begin
            if (rdy_q) ovr_ev = 1'b1;
            else       load   = 1'b1;
          end else begin
            ferr_ev = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load beats a coincident ack; error events beat a coincident clear.
  always_comb begin
    rdy_d  = load    ? 1'b1 : (ack     ? 1'b0 : rdy_q);
    ferr_d = ferr_ev ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
    ovr_d  = ovr_ev  ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_word
    d_en_ff u_ff (
      .clk  (clk),
      .CLRN (~CLR),
      .EN   (load),
      .D    (shreg_q[i]),
      .q    (word[i])
    );
  end

  assign rdy  = rdy_q;
  assign ferr = ferr_q;
  assign ovr  = ovr_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ser_word_capture.sv
// Randomized and directed bench for ser_word_capture against a frame-level model.
module tb_ser_word_capture;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             CLR = 1'b1;
  logic             sdata = 1'b1, sen = 1'b0, ack = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] word;
  logic             rdy, ferr, ovr, busy;

  int nchk = 0;
  int nerr = 0;

  // Reference model: a frame is a start 0 followed by WIDTH+1 collected strobes.
  bit             m_inframe;
  bit             m_bits[$];
  int unsigned    m_word;
  bit             m_rdy, m_ferr, m_ovr;

  ser_word_capture #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .CLR     (CLR),
    .sdata   (sdata),
    .sen     (sen),
    .ack     (ack),
    .clr_err (clr_err),
    .word    (word),
    .rdy     (rdy),
    .ferr    (ferr),
    .ovr     (ovr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inframe = 0;
    m_bits.delete();
    m_word = 0;
    m_rdy = 0;
    m_ferr = 0;
    m_ovr = 0;
  endtask

  task automatic model_step(input bit s, input bit d, input bit a, input bit c);
    bit ld, ov, fe;
    int unsigned val;
    ld = 0; ov = 0; fe = 0;
    if (s) begin
      if (!m_inframe) begin
        if (!d) begin
          m_inframe = 1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == WIDTH + 1) begin
          m_inframe = 0;
          if (m_bits[WIDTH]) begin
            if (m_rdy) ov = 1;
            else begin
              ld = 1;
              val = 0;
              for (int i = 0; i < WIDTH; i++) val += int'(m_bits[i]) * (1 << i);
              m_word = val;
            end
          end else fe = 1;
        end
      end
    end
    if (ld)     m_rdy = 1;
    else if (a) m_rdy = 0;
    if (fe)     m_ferr = 1;
    else if (c) m_ferr = 0;
    if (ov)     m_ovr = 1;
    else if (c) m_ovr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word"}, 32'(word), m_word);
    chk({tag, ".rdy"},  32'(rdy),  32'(m_rdy));
    chk({tag, ".ferr"}, 32'(ferr), 32'(m_ferr));
    chk({tag, ".ovr"},  32'(ovr),  32'(m_ovr));
    chk({tag, ".busy"}, 32'(busy), 32'(m_inframe));
  endtask

  // Inputs change at negedge, model advances at posedge, outputs checked next negedge.
  task automatic cycle(input bit s, input bit d, input bit a, input bit c, input string tag);
    sen = s; sdata = d; ack = a; clr_err = c;
    @(posedge clk);
    model_step(s, d, a, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 CLR = 1'b1;
    #1;
    model_reset();
    chk("rst.word", 32'(word), 0);
    chk("rst.rdy",  32'(rdy),  0);
    chk("rst.ferr", 32'(ferr), 0);
    chk("rst.ovr",  32'(ovr),  0);
    chk("rst.busy", 32'(busy), 0);
    @(negedge clk);
    CLR = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input bit stopb, input int gap,
                            input bit ack_start, input bit ack_stop, input string tag);
    bit b;
    for (int i = 0; i < WIDTH + 2; i++) begin
      if (i == 0)              b = 1'b0;
      else if (i == WIDTH + 1) b = stopb;
      else                     b = data[i-1];
      cycle(1'b1, b, (i == 0 && ack_start) || (i == WIDTH + 1 && ack_stop), 1'b0, tag);
      if (i != WIDTH + 1)
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'($urandom), 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    model_reset();
    sen = 0; sdata = 1; ack = 0; clr_err = 0;
    #1;
    chk("init.word", 32'(word), 0);
    chk("init.rdy",  32'(rdy),  0);
    chk("init.busy", 32'(busy), 0);
    @(negedge clk);
    CLR = 1'b0;

    // Reset mid-frame after 3 data bits, then a clean frame.
    cycle(1, 0, 0, 0, "mid.start");
    cycle(1, 1, 0, 0, "mid.b0");
    cycle(1, 0, 0, 0, "mid.b1");
    cycle(1, 1, 0, 0, "mid.b2");
    chk("mid.busy", 32'(busy), 1);
    do_reset();
    send_frame(8'hA5, 1, 0, 0, 0, "a5");
    chk("a5.word", 32'(word), 32'hA5);
    chk("a5.rdy",  32'(rdy),  1);
    cycle(0, 1, 1, 0, "a5.ack");

    // Nominal with idle clocks between strobes.
    send_frame(8'h3C, 1, 2, 0, 0, "3c");
    chk("3c.word", 32'(word), 32'h3C);
    chk("3c.rdy",  32'(rdy),  1);
    cycle(0, 0, 1, 0, "3c.ack");
    chk("3c.ackrdy",  32'(rdy),  0);
    chk("3c.ackword", 32'(word), 32'h3C);

    // Framing error.
    do_reset();
    send_frame(8'h55, 0, 1, 0, 0, "fe");
    chk("fe.ferr", 32'(ferr), 1);
    chk("fe.rdy",  32'(rdy),  0);
    chk("fe.word", 32'(word), 0);
    cycle(0, 1, 0, 1, "fe.clr");
    chk("fe.clrd", 32'(ferr), 0);

    // Overrun.
    send_frame(8'h11, 1, 0, 0, 0, "ov1");
    send_frame(8'h22, 1, 1, 0, 0, "ov2");
    chk("ov.ovr",  32'(ovr),  1);
    chk("ov.word", 32'(word), 32'h11);
    chk("ov.rdy",  32'(rdy),  1);
    cycle(0, 1, 1, 1, "ov.ack");
    send_frame(8'h33, 1, 0, 0, 0, "ov3");
    chk("ov3.word", 32'(word), 32'h33);
    chk("ov3.ovr",  32'(ovr),  0);
    cycle(0, 1, 1, 0, "ov3.ack");

    // Back-to-back; ack on second start strobe and again with the second stop.
    send_frame(8'h0F, 1, 0, 0, 0, "bb1");
    send_frame(8'hF0, 1, 0, 1, 1, "bb2");
    chk("bb.word", 32'(word), 32'hF0);
    chk("bb.rdy",  32'(rdy),  1);
    chk("bb.ovr",  32'(ovr),  0);
    cycle(0, 1, 1, 1, "bb.ack");

    // Idle line.
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, "idle");
    chk("idle.busy", 32'(busy), 0);
    chk("idle.rdy",  32'(rdy),  0);
    chk("idle.ferr", 32'(ferr), 0);
    chk("idle.ovr",  32'(ovr),  0);

    // Random traffic, with occasional async resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(($urandom_range(0, 9) < 6), 1'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
